mem_issue_queue: RTL and testbench

- Reservation station for load/store micro-ops, directly upstream of the memory functional unit.
- Accepts dispatched memory ops and tracks source-operand readiness via writeback tag broadcasts.
- Each cycle, issues the oldest eligible op to the memory unit, gated by the unit's ready signal.
- Flushes wrong-path entries on a branch mispredict.

---
 rtl/types_pkg.sv | 31 +++
 rtl/miq_age_select.sv | 30 +++
 rtl/mem_issue_queue.sv | 203 ++++++++++++++++++++
 tb/tb_mem_issue_queue.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types for the memory issue queue: entry bundle, opcodes, age helper.
// Ports: none (package only).
package types_pkg;

    localparam int MIQ_PREG_W = 7;
    localparam int MIQ_ROB_W  = 5;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef struct packed {
        logic [6:0]            opcode;
        logic [2:0]            func3;
        logic [MIQ_PREG_W-1:0] pd;
        logic [MIQ_PREG_W-1:0] ps1;
        logic                  ps1_rdy;
        logic [MIQ_PREG_W-1:0] ps2;
        logic                  ps2_rdy;
        logic [31:0]           imm;
        logic [MIQ_ROB_W-1:0]  rob_index;
    } miq_entry_t;

    // Distance from the ROB head; modular so the index wrap keeps ordering.
    function automatic logic [MIQ_ROB_W-1:0] age_of(
        input logic [MIQ_ROB_W-1:0] rob,
        input logic [MIQ_ROB_W-1:0] head
    );
        return rob - head;
    endfunction

endpackage

// File: rtl/miq_age_select.sv
// Combinational oldest-eligible picker (smallest age wins, low index breaks ties).
// Ports: eligible, ages in; one-hot grant and any_grant out.
module miq_age_select #(
    parameter int DEPTH = 8,
    parameter int AGE_W = 5
) (
    input  logic [DEPTH-1:0]            eligible,
    input  logic [DEPTH-1:0][AGE_W-1:0] ages,
    output logic [DEPTH-1:0]            grant,
    output logic                        any_grant
);

    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = eligible[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && eligible[j]) begin
                    if (ages[j] < ages[i] ||
                        (ages[j] == ages[i] && j < i)) begin
                        grant[i] = 1'b0;
                    end
                end
            end
        end
    end

    assign any_grant = |eligible;

endmodule

// File: rtl/mem_issue_queue.sv
// Load/store reservation station: dispatch, tag wakeup, oldest-first issue, flush.
// Ports: clk, reset (async active-low); dispatch_valid/entry/ready;
//        wb_valid/wb_tag wakeups; fu_ready, issued, issue_data;
//        rob_head age reference; mispredict/mispredict_tag flush; count.
// Build option: MIQ_LOAD_BYPASS_STORE_EN lets loads pass older stores.
module mem_issue_queue
    import types_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int NUM_WB = 3,
    parameter int PREG_W = MIQ_PREG_W,
    parameter int ROB_W  = MIQ_ROB_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dispatch_valid,
    input  miq_entry_t               dispatch_entry,
    output logic                     dispatch_ready,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*PREG_W-1:0] wb_tag,
    input  logic                     fu_ready,
    output logic                     issued,
    output miq_entry_t               issue_data,
    input  logic [ROB_W-1:0]         rob_head,
    input  logic                     mispredict,
    input  logic [ROB_W-1:0]         mispredict_tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    miq_entry_t             ent_q [DEPTH];
    miq_entry_t             ent_d [DEPTH];
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   issued_q;
    miq_entry_t             issue_data_q;

    logic [DEPTH-1:0]            wake1, wake2;
    logic                        disp_rdy1, disp_rdy2;
    logic [DEPTH-1:0][ROB_W-1:0] age;
    logic [ROB_W-1:0]            flush_age;
    logic [DEPTH-1:0]            is_load, is_store;
    logic [DEPTH-1:0]            load_blocked;
    logic [DEPTH-1:0]            eligible;
    logic [DEPTH-1:0]            grant;
    logic                        any_grant;
    logic                        do_issue, do_disp;
    logic                        have_free;
    logic [IDX_W-1:0]            free_idx;
    miq_entry_t                  issue_mux;

    assign dispatch_ready = (count_q < CNT_W'(DEPTH));
    assign count          = count_q;
    assign issued         = issued_q;
    assign issue_data     = issue_data_q;

    // Wakeup matches for stored entries and for the op being dispatched.
    always_comb begin
        wake1     = '0;
        wake2     = '0;
        disp_rdy1 = dispatch_entry.ps1_rdy || (dispatch_entry.ps1 == '0);
        disp_rdy2 = dispatch_entry.ps2_rdy || (dispatch_entry.ps2 == '0);
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_q[i].ps1 == wb_tag[k*PREG_W +: PREG_W])
                        wake1[i] = 1'b1;
                    if (ent_q[i].ps2 == wb_tag[k*PREG_W +: PREG_W])
                        wake2[i] = 1'b1;
                end
                if (dispatch_entry.ps1 == wb_tag[k*PREG_W +: PREG_W])
                    disp_rdy1 = 1'b1;
                if (dispatch_entry.ps2 == wb_tag[k*PREG_W +: PREG_W])
                    disp_rdy2 = 1'b1;
            end
        end
    end

    always_comb begin
        flush_age = age_of(mispredict_tag, rob_head);
        for (int i = 0; i < DEPTH; i++) begin
            age[i]      = age_of(ent_q[i].rob_index, rob_head);
            is_load[i]  = (ent_q[i].opcode == OPC_LOAD);
            is_store[i] = (ent_q[i].opcode == OPC_STORE);
        end
    end

`ifdef MIQ_LOAD_BYPASS_STORE_EN
    assign load_blocked = '0;
`else
    // A load waits while any older store is still resident.
    always_comb begin
        load_blocked = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (valid_q[j] && is_store[j] && age[j] < age[i])
                    load_blocked[i] = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        eligible = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                unique case (1'b1)
                    is_store[i]:
                        eligible[i] = ent_q[i].ps1_rdy && ent_q[i].ps2_rdy;
                    is_load[i]:
                        eligible[i] = ent_q[i].ps1_rdy && !load_blocked[i];
                    default:
                        eligible[i] = 1'b0;
                endcase
            end
        end
    end

    miq_age_select #(
        .DEPTH (DEPTH),
        .AGE_W (ROB_W)
    ) u_age_select (
        .eligible  (eligible),
        .ages      (age),
        .grant     (grant),
        .any_grant (any_grant)
    );

    always_comb begin
        issue_mux = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i])
                issue_mux = ent_q[i];
        end
    end

    // Lowest-index free slot; the descending scan leaves the smallest.
    always_comb begin
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
        end
    end

    assign do_issue = fu_ready && !mispredict && any_grant;
    assign do_disp  = dispatch_valid && dispatch_ready &&
                      !mispredict && have_free;

    always_comb begin
        valid_d = valid_q;
        ent_d   = ent_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && wake1[i])
                ent_d[i].ps1_rdy = 1'b1;
            if (valid_q[i] && wake2[i])
                ent_d[i].ps2_rdy = 1'b1;
            if (mispredict && age[i] > flush_age)
                valid_d[i] = 1'b0;
        end
        if (do_issue)
            valid_d = valid_d & ~grant;
        // Issue frees a slot only at the edge, so free_idx never aliases it.
        if (do_disp) begin
            valid_d[free_idx]         = 1'b1;
            ent_d[free_idx]           = dispatch_entry;
            ent_d[free_idx].ps1_rdy   = disp_rdy1;
            ent_d[free_idx].ps2_rdy   = disp_rdy2;
        end
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++)
            count_d = count_d + CNT_W'(valid_d[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= '0;
            count_q      <= '0;
            issued_q     <= 1'b0;
            issue_data_q <= '0;
        end else begin
            valid_q  <= valid_d;
            count_q  <= count_d;
            issued_q <= do_issue;
            if (do_issue)
                issue_data_q <= issue_mux;
        end
    end

    // Payload needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed self-checking bench for mem_issue_queue.
// Honors MIQ_LOAD_BYPASS_STORE_EN for the store-ordering case.
module tb_mem_issue_queue;
    import types_pkg::*;

    logic             clk;
    logic             reset;
    logic             dispatch_valid;
    miq_entry_t       dispatch_entry;
    logic             dispatch_ready;
    logic [2:0]       wb_valid;
    logic [20:0]      wb_tag;
    logic             fu_ready;
    logic             issued;
    miq_entry_t       issue_data;
    logic [4:0]       rob_head;
    logic             mispredict;
    logic [4:0]       mispredict_tag;
    logic [3:0]       count;

    int n_assert = 0;
    int n_fail   = 0;

    mem_issue_queue dut (
        .clk            (clk),
        .reset          (reset),
        .dispatch_valid (dispatch_valid),
        .dispatch_entry (dispatch_entry),
        .dispatch_ready (dispatch_ready),
        .wb_valid       (wb_valid),
        .wb_tag         (wb_tag),
        .fu_ready       (fu_ready),
        .issued         (issued),
        .issue_data     (issue_data),
        .rob_head       (rob_head),
        .mispredict     (mispredict),
        .mispredict_tag (mispredict_tag),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic miq_entry_t mk(
        input logic [6:0] opc,
        input logic [6:0] p1, input logic r1,
        input logic [6:0] p2, input logic r2,
        input logic [4:0] rob
    );
        miq_entry_t e;
        e           = '0;
        e.opcode    = opc;
        e.func3     = 3'd2;
        e.pd        = 7'(rob) + 7'd1;
        e.ps1       = p1;
        e.ps1_rdy   = r1;
        e.ps2       = p2;
        e.ps2_rdy   = r2;
        e.imm       = {27'd0, rob};
        e.rob_index = rob;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input miq_entry_t e);
        dispatch_valid = 1'b1;
        dispatch_entry = e;
        step();
        dispatch_valid = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        dispatch_valid = 1'b0;
        dispatch_entry = '0;
        wb_valid       = '0;
        wb_tag         = '0;
        fu_ready       = 1'b0;
        rob_head       = '0;
        mispredict     = 1'b0;
        mispredict_tag = '0;
        step();
        step();
        chk("rst_count", count, 0);
        chk("rst_issued", issued, 0);
        chk("rst_ready", dispatch_ready, 1);
        chk("rst_data", issue_data, 0);
        reset = 1'b1;
        step();

        // Wakeup then issue.
        fu_ready = 1'b1;
        disp(mk(OPC_LOAD, 7'd12, 1'b0, 7'd0, 1'b0, 5'd4));
        chk("wk_count", count, 1);
        chk("wk_wait", issued, 0);
        wb_valid = 3'b001;
        wb_tag   = {7'd0, 7'd0, 7'd12};
        step();
        wb_valid = '0;
        chk("wk_edge", issued, 0);
        step();
        chk("wk_issue", issued, 1);
        chk("wk_rob", issue_data.rob_index, 4);
        chk("wk_count0", count, 0);
        step();
        chk("wk_pulse", issued, 0);

        // Store ordering.
        fu_ready = 1'b0;
        disp(mk(OPC_STORE, 7'd0, 1'b1, 7'd20, 1'b0, 5'd5));
        disp(mk(OPC_LOAD, 7'd0, 1'b1, 7'd0, 1'b1, 5'd6));
        chk("so_count", count, 2);
        fu_ready = 1'b1;
        step();
`ifdef MIQ_LOAD_BYPASS_STORE_EN
        chk("so_ld_first", issued, 1);
        chk("so_ld_rob", issue_data.rob_index, 6);
        wb_valid = 3'b001;
        wb_tag   = {7'd0, 7'd0, 7'd20};
        step();
        wb_valid = '0;
        chk("so_wake", issued, 0);
        step();
        chk("so_st_iss", issued, 1);
        chk("so_st_rob", issue_data.rob_index, 5);
`else
        chk("so_block", issued, 0);
        wb_valid = 3'b001;
        wb_tag   = {7'd0, 7'd0, 7'd20};
        step();
        wb_valid = '0;
        chk("so_wake", issued, 0);
        step();
        chk("so_st_iss", issued, 1);
        chk("so_st_rob", issue_data.rob_index, 5);
        step();
        chk("so_ld_iss", issued, 1);
        chk("so_ld_rob", issue_data.rob_index, 6);
`endif
        chk("so_empty", count, 0);
        step();
        chk("so_idle", issued, 0);

        // Same-cycle bypass and x0 readiness.
        fu_ready = 1'b0;
        wb_valid = 3'b100;
        wb_tag   = {7'd33, 7'd0, 7'd0};
        disp(mk(OPC_LOAD, 7'd33, 1'b0, 7'd0, 1'b1, 5'd10));
        wb_valid = '0;
        disp(mk(OPC_STORE, 7'd0, 1'b0, 7'd0, 1'b0, 5'd11));
        fu_ready = 1'b1;
        step();
        chk("byp_rob", issue_data.rob_index, 10);
        chk("byp_rdy", issue_data.ps1_rdy, 1);
        step();
        chk("x0_iss", issued, 1);
        chk("x0_rob", issue_data.rob_index, 11);
        step();
        chk("byp_idle", issued, 0);

        // Oldest-first across the ROB wrap.
        fu_ready = 1'b0;
        rob_head = 5'd30;
        disp(mk(OPC_LOAD, 7'd0, 1'b1, 7'd0, 1'b1, 5'd2));
        disp(mk(OPC_LOAD, 7'd0, 1'b1, 7'd0, 1'b1, 5'd31));
        fu_ready = 1'b1;
        step();
        chk("wrap_first", issue_data.rob_index, 31);
        step();
        chk("wrap_second", issue_data.rob_index, 2);
        chk("wrap_count", count, 0);
        fu_ready = 1'b0;
        rob_head = 5'd0;
        step();

        // Full queue, drop, simultaneous dispatch and issue.
        for (int i = 0; i < 8; i++) begin
            disp(mk(OPC_LOAD, 7'd0, 1'b1, 7'd0, 1'b1, 5'(i)));
            chk("fill_count", count, 64'(i + 1));
        end
        chk("full_ready", dispatch_ready, 0);
        disp(mk(OPC_LOAD, 7'd0, 1'b1, 7'd0, 1'b1, 5'd9));
        chk("full_drop", count, 8);
        fu_ready = 1'b1;
        step();
        chk("full_iss", issue_data.rob_index, 0);
        chk("full_cnt7", count, 7);
        chk("full_ready1", dispatch_ready, 1);
        disp(mk(OPC_LOAD, 7'd0, 1'b1, 7'd0, 1'b1, 5'd8));
        chk("sim_iss", issue_data.rob_index, 1);
        chk("sim_count", count, 7);
        for (int i = 2; i <= 8; i++) begin
            step();
            chk("drain_iss", issued, 1);
            chk("drain_rob", issue_data.rob_index, 64'(i));
            chk("drain_count", count, 64'(8 - i));
        end
        step();
        chk("empty_idle", issued, 0);
        fu_ready = 1'b0;

        // Mispredict flush.
        disp(mk(OPC_LOAD, 7'd0, 1'b1, 7'd0, 1'b1, 5'd1));
        disp(mk(OPC_LOAD, 7'd0, 1'b1, 7'd0, 1'b1, 5'd3));
        disp(mk(OPC_LOAD, 7'd0, 1'b1, 7'd0, 1'b1, 5'd6));
        chk("mp_setup", count, 3);
        mispredict     = 1'b1;
        mispredict_tag = 5'd3;
        fu_ready       = 1'b1;
        disp(mk(OPC_LOAD, 7'd0, 1'b1, 7'd0, 1'b1, 5'd7));
        mispredict = 1'b0;
        fu_ready   = 1'b0;
        chk("mp_count", count, 2);
        chk("mp_noiss", issued, 0);
        step();
        chk("mp_nodisp", count, 2);
        fu_ready = 1'b1;
        step();
        chk("mp_iss1", issue_data.rob_index, 1);
        step();
        chk("mp_iss3", issue_data.rob_index, 3);
        step();
        chk("mp_gone", issued, 0);
        chk("mp_empty", count, 0);
        fu_ready = 1'b0;

        // Asynchronous reset mid-operation.
        for (int i = 1; i <= 4; i++)
            disp(mk(OPC_LOAD, 7'd0, 1'b1, 7'd0, 1'b1, 5'(i)));
        fu_ready = 1'b1;
        step();
        fu_ready = 1'b0;
        chk("ar_pre_iss", issued, 1);
        chk("ar_pre_cnt", count, 3);
        reset = 1'b0;
        #2;
        chk("ar_count", count, 0);
        chk("ar_issued", issued, 0);
        chk("ar_ready", dispatch_ready, 1);
        chk("ar_data", issue_data, 0);
        step();
        reset    = 1'b1;
        fu_ready = 1'b1;
        step();
        chk("ar_post_cnt", count, 0);
        chk("ar_post_iss", issued, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
